// File: rtl/pois_hist_pkg.sv
// Shared types and defaults for the Poisson-count histogram block.
// N_BIN_DEF matches the sampler's 4-bit output range 0..12.
package pois_hist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int N_BIN_DEF = 13;
    localparam int CNT_W_DEF = 32;
    localparam int WIN_W_DEF = 24;

    // Out-of-range counts fold into the top bin.
    function automatic logic [3:0] clamp_bin(input logic [3:0] s, input logic [3:0] top);
        if (s > top) begin
            clamp_bin = top;
        end else begin
            clamp_bin = s;
        end
    endfunction

endpackage

// File: rtl/pois_hist_bin.sv
// One histogram bin: saturating counter with synchronous clear and increment enable.
module pois_hist_bin #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up until all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !sat) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = &count_q;

endmodule

// File: rtl/pois_hist.sv
// Histogram of Poisson sampler counts over a programmed window, drained one
// bin per valid/ready handshake; also tracks the running sample sum.
module pois_hist
    import pois_hist_pkg::*;
#(
    parameter int N_BIN = N_BIN_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic [WIN_W-1:0]   WINDOW,
    input  logic               SAMPLE_VALID,
    input  logic [3:0]         SAMPLE,
    output logic               BUSY,
    output logic               RD_VALID,
    input  logic               RD_READY,
    output logic [3:0]         RD_BIN,
    output logic [CNT_W-1:0]   RD_COUNT,
    output logic               RD_LAST,
    output logic [CNT_W+3:0]   SUM,
    output logic               OVERFLOW,
    output logic               DONE
);

    localparam logic [3:0] TOP_BIN = 4'(N_BIN - 1);

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   window_q, window_d;
    logic [WIN_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W+3:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic [3:0]         rd_bin_q, rd_bin_d;
    logic               rd_last_q, rd_last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept_s;
    logic               bin_clr_s;
    logic               oor_s;
    logic               sat_hit_s;
    logic [3:0]         sample_bin_s;
    logic [N_BIN-1:0]   bin_inc_s;
    logic [N_BIN-1:0]   bin_sat_s;
    logic [CNT_W-1:0]   bin_cnt_s [N_BIN];
    logic [CNT_W-1:0]   rd_count_s;

    // Steer an accepted sample to its bin and flag saturation / range overflow.
    always_comb begin
        accept_s     = (state_q == ST_ACCUM) && SAMPLE_VALID;
        bin_clr_s    = (state_q == ST_IDLE) && START;
        sample_bin_s = clamp_bin(SAMPLE, TOP_BIN);
        oor_s        = accept_s && (int'(SAMPLE) >= N_BIN);
        bin_inc_s    = '0;
        for (int i = 0; i < N_BIN; i++) begin
            bin_inc_s[i] = accept_s && (sample_bin_s == 4'(i));
        end
        sat_hit_s    = |(bin_inc_s & bin_sat_s);
    end

    for (genvar g = 0; g < N_BIN; g++) begin : g_bin
        pois_hist_bin #(.CNT_W(CNT_W)) u_bin (
            .clk     (CLK),
            .reset_n (RESET_N),
            .clr     (bin_clr_s),
            .inc     (bin_inc_s[g]),
            .count   (bin_cnt_s[g]),
            .sat     (bin_sat_s[g])
        );
    end

    // Window control FSM and drain sequencing.
    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        ovf_d      = ovf_q;
        rd_valid_d = rd_valid_q;
        rd_bin_d   = rd_bin_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    window_d = WINDOW;
                    cnt_d    = '0;
                    sum_d    = '0;
                    ovf_d    = 1'b0;
                    rd_bin_d = 4'd0;
                    if (WINDOW == '0) begin
                        state_d    = ST_DRAIN;
                        rd_valid_d = 1'b1;
                    end else begin
                        state_d    = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (SAMPLE_VALID) begin
                    cnt_d = cnt_q + WIN_W'(1);
                    sum_d = sum_q + (CNT_W + 4)'(SAMPLE);
                    ovf_d = ovf_q | oor_s | sat_hit_s;
                    if (cnt_d == window_q) begin
                        state_d    = ST_DRAIN;
                        rd_valid_d = 1'b1;
                        rd_bin_d   = 4'd0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (RD_READY) begin
                    if (rd_bin_q == TOP_BIN) begin
                        state_d    = ST_IDLE;
                        rd_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        rd_bin_d = rd_bin_q + 4'd1;
                    end
                end else begin
                    rd_bin_d = rd_bin_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
        rd_last_d = rd_valid_d && (rd_bin_d == TOP_BIN);
        busy_d    = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            window_q   <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bin_q   <= 4'd0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_bin_q   <= rd_bin_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Present the selected bin; selection and bins are both registered.
    always_comb begin
        rd_count_s = '0;
        for (int i = 0; i < N_BIN; i++) begin
            if (rd_bin_q == 4'(i)) begin
                rd_count_s = bin_cnt_s[i];
            end else begin
                rd_count_s = rd_count_s;
            end
        end
    end

    assign BUSY     = busy_q;
    assign RD_VALID = rd_valid_q;
    assign RD_BIN   = rd_bin_q;
    assign RD_COUNT = rd_count_s;
    assign RD_LAST  = rd_last_q;
    assign SUM      = sum_q;
    assign OVERFLOW = ovf_q;
    assign DONE     = done_q;

endmodule
